// File: rtl/qsfp_i2c_arbiter.sv
// Arbitrates the shared QSFP I2C engine between the poller and software, prepending
// a TCA9548 channel-select write when the cached channel differs, with a watchdog.
module qsfp_i2c_arbiter #(
  parameter int         QSFP_COUNT   = 2,
  parameter logic [6:0] MUX_ADDR     = 7'h70,
  parameter int         CLOCK_RATE   = 100_000_000,
  parameter int         TIMEOUT_US   = 2000,
  parameter int         RESET_CYCLES = 100,
  localparam int        CH_W         = (QSFP_COUNT > 1) ? $clog2(QSFP_COUNT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sw_req,
  input  logic [CH_W-1:0] sw_chan,
  input  logic [6:0]      sw_dev,
  input  logic [7:0]      sw_reg,
  input  logic            sw_rnw,
  input  logic [7:0]      sw_wdata,
  output logic            sw_ack,
  output logic            sw_err,
  input  logic            poll_req,
  input  logic [CH_W-1:0] poll_chan,
  input  logic [6:0]      poll_dev,
  input  logic [7:0]      poll_reg,
  input  logic            poll_rnw,
  input  logic [7:0]      poll_wdata,
  output logic            poll_ack,
  output logic            poll_err,
  output logic [7:0]      rdata,
  input  logic            freeze,
  output logic            eng_start,
  output logic [6:0]      eng_dev,
  output logic [7:0]      eng_reg,
  output logic            eng_noreg,
  output logic            eng_rnw,
  output logic [7:0]      eng_wdata,
  input  logic            eng_done,
  input  logic            eng_nack,
  input  logic [7:0]      eng_rdata,
  output logic            busmux_reset,
  output logic            run_stat,
  output logic [2:0]      dbg_state
);

  // Handshake: a requester holds req (and its fields) high until its one-cycle ack;
  // err and rdata are valid in the ack cycle. Toward the engine, eng_start is a
  // one-cycle command and eng_done a one-cycle response carrying eng_nack/eng_rdata.

  localparam longint TO_CYC = (longint'(TIMEOUT_US) * longint'(CLOCK_RATE)) / longint'(1_000_000);
  localparam int WD_W = $clog2(TO_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MUX_START  = 3'd1,
    S_MUX_WAIT   = 3'd2,
    S_XFER_START = 3'd3,
    S_XFER_WAIT  = 3'd4,
    S_RESP       = 3'd5,
    S_BUSRESET   = 3'd6
  } state_t;

  state_t          r_state;
  logic            r_last_sw;
  logic            r_gnt_sw;
  logic [CH_W-1:0] r_chan;
  logic [6:0]      r_dev;
  logic [7:0]      r_reg;
  logic            r_rnw;
  logic [7:0]      r_wdata;
  logic            r_chan_valid;
  logic [CH_W-1:0] r_cur_chan;
  logic [WD_W-1:0] r_wdog;
  logic [RC_W-1:0] r_rst_cnt;
  logic            r_sw_ack, r_sw_err, r_poll_ack, r_poll_err;
  logic [7:0]      r_rdata;
  logic            r_eng_start, r_eng_noreg, r_eng_rnw;
  logic [6:0]      r_eng_dev;
  logic [7:0]      r_eng_reg, r_eng_wdata;
  logic            r_busmux_reset;
  logic            r_run_stat;

  logic            w_sw_elig, w_poll_elig, w_pick_sw;
  logic [CH_W-1:0] w_req_chan;

  // On a tie the requester that did not win last time is picked.
  assign w_sw_elig   = sw_req;
  assign w_poll_elig = poll_req & ~freeze;
  assign w_pick_sw   = w_sw_elig & (~w_poll_elig | ~r_last_sw);
  assign w_req_chan  = w_pick_sw ? sw_chan : poll_chan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_sw      <= 1'b0;
      r_gnt_sw       <= 1'b0;
      r_chan         <= '0;
      r_dev          <= '0;
      r_reg          <= '0;
      r_rnw          <= 1'b0;
      r_wdata        <= '0;
      r_chan_valid   <= 1'b0;
      r_cur_chan     <= '0;
      r_wdog         <= '0;
      r_rst_cnt      <= '0;
      r_sw_ack       <= 1'b0;
      r_sw_err       <= 1'b0;
      r_poll_ack     <= 1'b0;
      r_poll_err     <= 1'b0;
      r_rdata        <= '0;
      r_eng_start    <= 1'b0;
      r_eng_dev      <= '0;
      r_eng_reg      <= '0;
      r_eng_noreg    <= 1'b0;
      r_eng_rnw      <= 1'b0;
      r_eng_wdata    <= '0;
      r_busmux_reset <= 1'b0;
      r_run_stat     <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      r_sw_ack    <= 1'b0;
      r_sw_err    <= 1'b0;
      r_poll_ack  <= 1'b0;
      r_poll_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sw_elig || w_poll_elig) begin
            r_gnt_sw   <= w_pick_sw;
            r_last_sw  <= w_pick_sw;
            r_chan     <= w_req_chan;
            r_dev      <= w_pick_sw ? sw_dev   : poll_dev;
            r_reg      <= w_pick_sw ? sw_reg   : poll_reg;
            r_rnw      <= w_pick_sw ? sw_rnw   : poll_rnw;
            r_wdata    <= w_pick_sw ? sw_wdata : poll_wdata;
            r_run_stat <= 1'b1;
            r_state    <= (!r_chan_valid || (w_req_chan != r_cur_chan)) ? S_MUX_START : S_XFER_START;
          end
        end
        S_MUX_START: begin
          r_eng_start <= 1'b1;
          r_eng_dev   <= MUX_ADDR;
          r_eng_reg   <= 8'h00;
          r_eng_noreg <= 1'b1;
          r_eng_rnw   <= 1'b0;
          r_eng_wdata <= 8'd1 << r_chan;
          r_wdog      <= '0;
          r_state     <= S_MUX_WAIT;
        end
        S_XFER_START: begin
          r_eng_start <= 1'b1;
          r_eng_dev   <= r_dev;
          r_eng_reg   <= r_reg;
          r_eng_noreg <= 1'b0;
          r_eng_rnw   <= r_rnw;
          r_eng_wdata <= r_wdata;
          r_wdog      <= '0;
          r_state     <= S_XFER_WAIT;
        end
        S_MUX_WAIT, S_XFER_WAIT: begin
          // A completion in the same cycle as the terminal count takes priority.
          if (eng_done) begin
            if (r_state == S_XFER_WAIT) begin
              r_rdata    <= eng_rdata;
              r_sw_ack   <= r_gnt_sw;
              r_poll_ack <= ~r_gnt_sw;
              r_sw_err   <= r_gnt_sw & eng_nack;
              r_poll_err <= ~r_gnt_sw & eng_nack;
              r_state    <= S_RESP;
            end else if (eng_nack) begin
              r_chan_valid <= 1'b0;
              r_sw_ack     <= r_gnt_sw;
              r_poll_ack   <= ~r_gnt_sw;
              r_sw_err     <= r_gnt_sw;
              r_poll_err   <= ~r_gnt_sw;
              r_state      <= S_RESP;
            end else begin
              r_cur_chan   <= r_chan;
              r_chan_valid <= 1'b1;
              r_state      <= S_XFER_START;
            end
          end else if (r_wdog == WD_LAST) begin
            r_chan_valid   <= 1'b0;
            r_busmux_reset <= 1'b1;
            r_rst_cnt      <= '0;
            r_state        <= S_BUSRESET;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_BUSRESET: begin
          if (r_rst_cnt == RC_LAST) begin
            r_busmux_reset <= 1'b0;
            r_sw_ack       <= r_gnt_sw;
            r_poll_ack     <= ~r_gnt_sw;
            r_sw_err       <= r_gnt_sw;
            r_poll_err     <= ~r_gnt_sw;
            r_state        <= S_RESP;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_run_stat <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sw_ack       = r_sw_ack;
  assign sw_err       = r_sw_err;
  assign poll_ack     = r_poll_ack;
  assign poll_err     = r_poll_err;
  assign rdata        = r_rdata;
  assign eng_start    = r_eng_start;
  assign eng_dev      = r_eng_dev;
  assign eng_reg      = r_eng_reg;
  assign eng_noreg    = r_eng_noreg;
  assign eng_rnw      = r_eng_rnw;
  assign eng_wdata    = r_eng_wdata;
  assign busmux_reset = r_busmux_reset;
  assign run_stat     = r_run_stat;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_qsfp_i2c_arbiter.sv
// Directed bench for qsfp_i2c_arbiter: a simple engine responder and hand-computed
// expectations for grant order, mux caching, freeze, watchdog, NACK and reset.
module tb_qsfp_i2c_arbiter;

  logic       clk, rst;
  logic       sw_req, poll_req, freeze;
  logic [0:0] sw_chan, poll_chan;
  logic [6:0] sw_dev, poll_dev;
  logic [7:0] sw_reg, poll_reg, sw_wdata, poll_wdata;
  logic       sw_rnw, poll_rnw;
  logic       sw_ack, sw_err, poll_ack, poll_err;
  logic [7:0] rdata;
  logic       eng_start, eng_noreg, eng_rnw, eng_done, eng_nack;
  logic [6:0] eng_dev;
  logic [7:0] eng_reg, eng_wdata, eng_rdata;
  logic       busmux_reset, run_stat;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  qsfp_i2c_arbiter #(
    .QSFP_COUNT(2), .MUX_ADDR(7'h70), .CLOCK_RATE(100_000_000),
    .TIMEOUT_US(1), .RESET_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_chan(sw_chan), .sw_dev(sw_dev), .sw_reg(sw_reg),
    .sw_rnw(sw_rnw), .sw_wdata(sw_wdata), .sw_ack(sw_ack), .sw_err(sw_err),
    .poll_req(poll_req), .poll_chan(poll_chan), .poll_dev(poll_dev), .poll_reg(poll_reg),
    .poll_rnw(poll_rnw), .poll_wdata(poll_wdata), .poll_ack(poll_ack), .poll_err(poll_err),
    .rdata(rdata), .freeze(freeze),
    .eng_start(eng_start), .eng_dev(eng_dev), .eng_reg(eng_reg), .eng_noreg(eng_noreg),
    .eng_rnw(eng_rnw), .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_nack(eng_nack),
    .eng_rdata(eng_rdata), .busmux_reset(busmux_reset), .run_stat(run_stat),
    .dbg_state(dbg_state)
  );

  // Clock and a hard stop in case the sequence hangs.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL tb_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int n_sw_ack = 0, n_poll_ack = 0;
  always @(negedge clk) begin
    if (sw_ack)   n_sw_ack++;
    if (poll_ack) n_poll_ack++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First and last engine command seen by service(), plus the ack it ended on.
  logic [6:0] f_dev, l_dev;
  logic [7:0] f_reg, l_reg, f_wdata, l_wdata, a_rd;
  logic       f_noreg, l_noreg, f_rnw, l_rnw, a_sw, a_poll, a_err;
  int         n_st;

  // Acts as the engine until an ack appears; returns at the ack cycle.
  task automatic service(input logic nack_mux, input logic [7:0] rd);
    logic got;
    got = 1'b0; n_st = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      eng_done = 1'b0; eng_nack = 1'b0;
      if (sw_ack || poll_ack) begin
        got = 1'b1; a_sw = sw_ack; a_poll = poll_ack; a_err = sw_err | poll_err; a_rd = rdata;
      end else if (eng_start) begin
        if (n_st == 0) begin
          f_dev = eng_dev; f_reg = eng_reg; f_noreg = eng_noreg; f_rnw = eng_rnw; f_wdata = eng_wdata;
        end
        l_dev = eng_dev; l_reg = eng_reg; l_noreg = eng_noreg; l_rnw = eng_rnw; l_wdata = eng_wdata;
        n_st++;
        eng_done  = 1'b1;
        eng_nack  = eng_noreg & nack_mux;
        eng_rdata = eng_noreg ? 8'hEE : rd;
      end
    end
    if (!got) chk("svc_ack_timeout", 0, 1);
  endtask

  int   cnt, delay, high, snap_sw, snap_poll;
  logic ok;

  initial begin
    rst = 1'b1; freeze = 1'b0;
    sw_req = 0; sw_chan = 0; sw_dev = 0; sw_reg = 0; sw_rnw = 0; sw_wdata = 0;
    poll_req = 0; poll_chan = 0; poll_dev = 0; poll_reg = 0; poll_rnw = 0; poll_wdata = 0;
    eng_done = 0; eng_nack = 0; eng_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_run_stat", run_stat, 0);
    chk("rst_busmux_reset", busmux_reset, 0);
    chk("rst_acks", {sw_ack, poll_ack, sw_err, poll_err}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single poll read on channel 1: mux select 0x02, then the read.
    poll_chan = 1; poll_dev = 7'h50; poll_reg = 8'h16; poll_rnw = 1; poll_req = 1;
    service(1'b0, 8'hA5);
    poll_req = 0;
    chk("t1_mux_dev", f_dev, 7'h70);
    chk("t1_mux_noreg", f_noreg, 1);
    chk("t1_mux_rnw", f_rnw, 0);
    chk("t1_mux_wdata", f_wdata, 8'h02);
    chk("t1_xfer_dev", l_dev, 7'h50);
    chk("t1_xfer_reg", l_reg, 8'h16);
    chk("t1_xfer_rnw", l_rnw, 1);
    chk("t1_xfer_noreg", l_noreg, 0);
    chk("t1_starts", n_st, 2);
    chk("t1_ack", {a_sw, a_poll, a_err}, 3'b010);
    chk("t1_rdata", a_rd, 8'hA5);
    @(negedge clk);
    chk("t1_run_stat_after", run_stat, 0);
    chk("t1_ack_single", poll_ack, 0);

    // Same channel again: cached, so only the transfer is issued.
    poll_req = 1;
    service(1'b0, 8'h3C);
    poll_req = 0;
    chk("t2_starts", n_st, 1);
    chk("t2_noreg", f_noreg, 0);
    chk("t2_rdata", a_rd, 8'h3C);
    @(negedge clk);
    poll_chan = 0; poll_req = 1;
    service(1'b0, 8'h5A);
    poll_req = 0;
    chk("t2b_starts", n_st, 2);
    chk("t2b_mux_noreg", f_noreg, 1);
    chk("t2b_mux_wdata", f_wdata, 8'h01);
    chk("t2b_xfer_dev", l_dev, 7'h50);
    @(negedge clk);

    // Tie straight out of reset: sw, poll, sw while both requests stay high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sw_chan = 0; sw_dev = 7'h51; sw_reg = 8'h01; sw_rnw = 0; sw_wdata = 8'h77; sw_req = 1;
    poll_chan = 1; poll_req = 1;
    service(1'b0, 8'h00);
    chk("t3_first_sw", {a_sw, a_poll}, 2'b10);
    chk("t3_sw_reg", l_reg, 8'h01);
    chk("t3_sw_rnw", l_rnw, 0);
    chk("t3_sw_wdata", l_wdata, 8'h77);
    service(1'b0, 8'h44);
    chk("t3_second_poll", {a_sw, a_poll}, 2'b01);
    chk("t3_poll_rdata", a_rd, 8'h44);
    service(1'b0, 8'h00);
    chk("t3_third_sw", {a_sw, a_poll}, 2'b10);
    sw_req = 0; poll_req = 0;
    @(negedge clk);

    // freeze holds off the poller while software still gets through.
    freeze = 1; poll_req = 1; sw_rnw = 1; sw_req = 1;
    service(1'b0, 8'h66);
    sw_req = 0;
    chk("t4_sw_granted", {a_sw, a_poll}, 2'b10);
    snap_poll = n_poll_ack;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (run_stat || eng_start) cnt++;
    end
    chk("t4_frozen_idle", cnt, 0);
    chk("t4_frozen_no_ack", n_poll_ack - snap_poll, 0);
    freeze = 0;
    delay = 0;
    for (int i = 0; i < 5 && !run_stat; i++) begin
      @(negedge clk);
      delay++;
    end
    chk("t4_unfreeze_latency", (delay >= 1 && delay <= 2), 1);
    service(1'b0, 8'h11);
    poll_req = 0;
    chk("t4_poll_ack", {a_sw, a_poll, a_err}, 3'b010);
    chk("t4_poll_rdata", a_rd, 8'h11);
    @(negedge clk);

    // Engine never answers: watchdog, busmux_reset pulse, error ack.
    sw_chan = 1; sw_req = 1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (eng_start) ok = 1;
    end
    chk("t5_start_seen", ok, 1);
    delay = 0;
    while (!busmux_reset && delay < 300) begin
      @(negedge clk);
      delay++;
    end
    chk("t5_timeout_cycles", delay, 100);
    high = 0;
    while (busmux_reset && high < 100) begin
      high++;
      @(negedge clk);
    end
    chk("t5_reset_width", high, 20);
    chk("t5_ack_err", {sw_ack, sw_err, poll_ack}, 3'b110);
    chk("t5_rdata_kept", rdata, 8'h11);
    sw_req = 0;
    @(negedge clk);
    poll_chan = 1; poll_req = 1;
    service(1'b0, 8'h22);
    poll_req = 0;
    chk("t5_mux_repeated", {f_noreg, f_wdata}, {1'b1, 8'h02});
    chk("t5_starts", n_st, 2);
    @(negedge clk);

    // Mux select NACK: error ack, no transfer, rdata untouched.
    sw_chan = 0; sw_req = 1;
    service(1'b1, 8'h99);
    sw_req = 0;
    chk("t6_ack_err", {a_sw, a_poll, a_err}, 3'b101);
    chk("t6_starts", n_st, 1);
    chk("t6_rdata_kept", a_rd, 8'h22);
    @(negedge clk);

    // Reset during XFER_WAIT aborts without an ack.
    poll_chan = 0; poll_req = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (eng_start) ok = 1;
    end
    chk("t7_mux_start", {ok, eng_noreg}, 2'b11);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (eng_start) ok = 1;
    end
    chk("t7_xfer_start", {ok, eng_noreg}, 2'b10);
    snap_sw = n_sw_ack; snap_poll = n_poll_ack;
    rst = 1; poll_req = 0;
    @(negedge clk);
    chk("t7_outputs_zero", {eng_start, eng_noreg, eng_rnw, run_stat, busmux_reset,
                             sw_ack, poll_ack, sw_err, poll_err}, 0);
    chk("t7_eng_bus_zero", {eng_dev, eng_reg, eng_wdata}, 0);
    chk("t7_rdata_zero", rdata, 0);
    chk("t7_state_idle", dbg_state, 0);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("t7_no_ack", (n_sw_ack - snap_sw) + (n_poll_ack - snap_poll), 0);
    chk("t7_idle_after", run_stat, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qsfp_i2c_arbiter.md
Name: qsfp_i2c_arbiter

Overview:
Shares the single I2C transaction engine on the Marble QSFP bus between two requesters: the periodic QSFP poller and software (CSR) one-shot accesses. Before each granted transaction it sequences the TCA9548 bus-mux channel-select write, skipping it when the cached channel already matches. It also enforces a transaction watchdog that drives busmux_reset. The block sits between the requesters and the I2C bit engine, in the qsfpMarble clock domain.

Parameters:
QSFP_COUNT, 2, number of mux channels in use (1..8); CH_W = max(1,$clog2(QSFP_COUNT)).
MUX_ADDR, 7'h70, 7-bit I2C address of the bus mux.
CLOCK_RATE, 100_000_000, clk frequency in Hz.
TIMEOUT_US, 2000, watchdog limit per engine transaction, in µs.
RESET_CYCLES, 100, busmux_reset pulse width, in clk cycles.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sw_req / poll_req  in  1  request level; hold until matching ack
sw_chan / poll_chan  in  CH_W  QSFP mux channel
sw_dev / poll_dev  in  7  target device address
sw_reg / poll_reg  in  8  register address
sw_rnw / poll_rnw  in  1  1=read, 0=write
sw_wdata / poll_wdata  in  8  write data
sw_ack / poll_ack  out  1  one-cycle completion pulse
sw_err / poll_err  out  1  valid with ack: NACK or timeout
rdata  out  8  read data, valid with either ack
freeze  in  1  block new poll grants
eng_start  out  1  one-cycle start to engine
eng_dev  out  7  engine device address
eng_reg  out  8  engine register byte
eng_noreg  out  1  1 = skip register byte (mux write)
eng_rnw  out  1  engine direction
eng_wdata  out  8  engine write data
eng_done  in  1  one-cycle engine completion
eng_nack  in  1  valid with eng_done
eng_rdata  in  8  valid with eng_done
busmux_reset  out  1  mux reset, active high
run_stat  out  1  1 when state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; chan_valid=0; last_grant=POLL (SW wins the first tie); counters cleared. Reset mid-transaction aborts it with no ack.
- Eligibility: sw eligible when sw_req=1. Poll eligible when poll_req=1 and freeze=0. freeze does not affect a transaction already granted.
- IDLE: if one requester is eligible, grant it. If both are eligible, grant round-robin (the one not equal to last_grant). On grant, latch the requester's fields and set last_grant; the grant decision takes 1 cycle.
- Next state after grant: MUX_START if !chan_valid or latched chan != cur_chan, otherwise XFER_START.
- MUX_START: eng_start=1 for 1 cycle with eng_dev=MUX_ADDR, eng_noreg=1, eng_rnw=0, eng_wdata=1<<chan. Then MUX_WAIT.
- MUX_WAIT on eng_done:
  - nack=1: chan_valid=0, go to RESP with err=1.
  - nack=0: cur_chan=chan, chan_valid=1, go to XFER_START.
- XFER_START: eng_start pulse with the latched dev/reg/rnw/wdata and eng_noreg=0. Then XFER_WAIT.
- XFER_WAIT on eng_done: capture eng_rdata, err=eng_nack, go to RESP.
- RESP: ack for the granted requester = 1 for exactly 1 cycle. rdata holds its value until the next RESP. Return to IDLE. A requester may drop req the cycle after ack; req still high in IDLE is a new request.
- Watchdog: counter loads at each eng_start and counts in the *_WAIT states. On reaching TIMEOUT_US*CLOCK_RATE/1e6 cycles go to BUSRESET.
- BUSRESET: busmux_reset=1 for RESET_CYCLES, chan_valid=0, then RESP with err=1 and rdata unchanged.
- Simultaneous eng_done and watchdog terminal count: done wins.
- eng_done outside the *_WAIT states is ignored.
- Only one ack is produced per grant. An ack is never produced for a requester that was not granted.

Test Plan:
- Single poll read: poll_req with chan=1, dev=0x50, reg=0x16, rnw=1. Required: mux write 0x02 to 0x70 with noreg=1, then read. Engine returns 0xA5 → poll_ack for 1 cycle, rdata=0xA5, err=0, run_stat low after.
- Repeat the same-channel poll: no mux write, only 1 eng_start. Then switch to chan=0: mux write data 0x01 precedes the transfer.
- sw_req and poll_req asserted in the same cycle from reset: sw granted first, poll second. Hold both requests continuously: grants alternate sw, poll, sw.
- freeze=1 with poll_req held: no grant for 1000 cycles while an sw request completes. Drop freeze: poll granted within 2 cycles.
- Engine never returns eng_done: busmux_reset high for exactly RESET_CYCLES after the timeout, then ack with err=1. Next request repeats the mux write (cache invalidated).
- Mux write NACK: ack with err=1, no data transfer issued. rst asserted during XFER_WAIT: all outputs 0 next cycle, no ack, state IDLE.
